// File: rtl/arm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : arm_pkg                                                |
// | Description : ALU command codes, condition codes and status flag     |
// |               bit positions shared by EXE, ID and control logic.     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package arm_pkg;

   // ALU command codes
   localparam logic [3:0] ALU_MOV = 4'b0001;
   localparam logic [3:0] ALU_MVN = 4'b1001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_ADC = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0100;   // also CMP
   localparam logic [3:0] ALU_SBC = 4'b0101;
   localparam logic [3:0] ALU_AND = 4'b0110;   // also TST
   localparam logic [3:0] ALU_ORR = 4'b0111;
   localparam logic [3:0] ALU_EOR = 4'b1000;

   // Condition codes
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   // Flag bit positions inside the 4-bit status word {N,Z,C,V}
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // True for commands that are allowed to update the flags
   function automatic logic is_flag_cmd(input logic [3:0] cmd);
      case (cmd)
         ALU_MOV, ALU_MVN, ALU_ADD, ALU_ADC, ALU_SUB,
         ALU_SBC, ALU_AND, ALU_ORR, ALU_EOR: is_flag_cmd = 1'b1;
         default:                            is_flag_cmd = 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/exe_mem_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : exe_mem_stage_if                                       |
// | Description : EXE-side inputs, hazard controls and EXE/MEM register  |
// |               outputs of the EXE/MEM stage.                          |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface exe_mem_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
);
   logic              exe_valid;
   logic [3:0]        alu_cmd;
   logic [DATA_W-1:0] val1;
   logic [DATA_W-1:0] val2;
   logic [DATA_W-1:0] alu_out;
   logic              s_bit;
   logic              wb_en;
   logic              mem_r;
   logic              mem_w;
   logic [REG_AW-1:0] dest;
   logic [DATA_W-1:0] st_val;
   logic              freeze;
   logic              flush;
   logic [3:0]        id_cond;

   logic [3:0]        status;
   logic              status_c;
   logic              cond_pass;
   logic              mem_valid;
   logic [DATA_W-1:0] mem_alu_res;
   logic [DATA_W-1:0] mem_st_val;
   logic [REG_AW-1:0] mem_dest;
   logic              mem_wb_en;
   logic              mem_mem_r;
   logic              mem_mem_w;

   // Upstream side: EXE stage, hazard unit and ID condition field
   modport master (
      output exe_valid, alu_cmd, val1, val2, alu_out, s_bit, wb_en, mem_r,
             mem_w, dest, st_val, freeze, flush, id_cond,
      input  status, status_c, cond_pass, mem_valid, mem_alu_res,
             mem_st_val, mem_dest, mem_wb_en, mem_mem_r, mem_mem_w
   );

   // Stage side
   modport slave (
      input  exe_valid, alu_cmd, val1, val2, alu_out, s_bit, wb_en, mem_r,
             mem_w, dest, st_val, freeze, flush, id_cond,
      output status, status_c, cond_pass, mem_valid, mem_alu_res,
             mem_st_val, mem_dest, mem_wb_en, mem_mem_r, mem_mem_w
   );
endinterface
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cond_check                                             |
// | Description : Evaluates a 4-bit condition field against {N,Z,C,V}.   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module cond_check
   import arm_pkg::*;
(
   input  logic [3:0] id_cond,
   input  logic [3:0] status,
   output logic       cond_pass
);
   logic w_n, w_z, w_c, w_v;

   assign w_n = status[FLAG_N];
   assign w_z = status[FLAG_Z];
   assign w_c = status[FLAG_C];
   assign w_v = status[FLAG_V];

   // Condition decode table
   always_comb begin
      cond_pass = 1'b0;
      case (id_cond)
         COND_EQ: cond_pass = w_z;
         COND_NE: cond_pass = ~w_z;
         COND_CS: cond_pass = w_c;
         COND_CC: cond_pass = ~w_c;
         COND_MI: cond_pass = w_n;
         COND_PL: cond_pass = ~w_n;
         COND_VS: cond_pass = w_v;
         COND_VC: cond_pass = ~w_v;
         COND_HI: cond_pass = w_c & ~w_z;
         COND_LS: cond_pass = ~w_c | w_z;
         COND_GE: cond_pass = (w_n == w_v);
         COND_LT: cond_pass = (w_n != w_v);
         COND_GT: cond_pass = ~w_z & (w_n == w_v);
         COND_LE: cond_pass = w_z | (w_n != w_v);
         COND_AL: cond_pass = 1'b1;
         COND_NV: cond_pass = 1'b0;
         default: cond_pass = 1'b0;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/exe_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : exe_mem_stage                                          |
// | Description : NZCV flag generation, status register, ID condition    |
// |               check and the EXE/MEM pipeline register.              |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module exe_mem_stage
   import arm_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   exe_mem_stage_if.slave  bus
);
   localparam int MSB = DATA_W - 1;

   logic [3:0]        r_status;
   logic              r_valid;
   logic [DATA_W-1:0] r_alu_res;
   logic [DATA_W-1:0] r_st_val;
   logic [REG_AW-1:0] r_dest;
   logic              r_wb_en;
   logic              r_mem_r;
   logic              r_mem_w;

   logic              w_cin;
   logic              w_bin;
   logic              w_add_c;
   logic              w_sub_c;
   logic [3:0]        w_flags;
   logic              w_status_we;

   assign w_cin = (bus.alu_cmd == ALU_ADC) & r_status[FLAG_C];
   assign w_bin = (bus.alu_cmd == ALU_SBC) & ~r_status[FLAG_C];

   // Carry out of val1+val2+cin; only the top bit of the widened sum matters
   assign w_add_c = ((({1'b0, bus.val1} + {1'b0, bus.val2}
                      + {{DATA_W{1'b0}}, w_cin}) >> DATA_W) != '0);
   // Carry for subtraction is the ARM not-borrow
   assign w_sub_c = ((({1'b0, bus.val1} - {1'b0, bus.val2}
                      - {{DATA_W{1'b0}}, w_bin}) >> DATA_W) == '0);

   // Next flag values; C and V pass through for logical/move commands
   always_comb begin
      w_flags         = r_status;
      w_flags[FLAG_N] = bus.alu_out[MSB];
      w_flags[FLAG_Z] = (bus.alu_out == '0);
      case (bus.alu_cmd)
         ALU_ADD, ALU_ADC: begin
            w_flags[FLAG_C] = w_add_c;
            w_flags[FLAG_V] = (bus.val1[MSB] == bus.val2[MSB])
                            & (bus.alu_out[MSB] != bus.val1[MSB]);
         end
         ALU_SUB, ALU_SBC: begin
            w_flags[FLAG_C] = w_sub_c;
            w_flags[FLAG_V] = (bus.val1[MSB] != bus.val2[MSB])
                            & (bus.alu_out[MSB] != bus.val1[MSB]);
         end
         default: ;
      endcase
   end

   assign w_status_we = bus.exe_valid & bus.s_bit & ~bus.flush & ~bus.freeze
                      & is_flag_cmd(bus.alu_cmd);

   // Architectural status register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_status <= 4'b0000;
      end else if (w_status_we) begin
         r_status <= w_flags;
      end
   end

   // EXE/MEM pipeline register; flush wins over freeze
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_alu_res <= '0;
         r_st_val  <= '0;
         r_dest    <= '0;
         r_wb_en   <= 1'b0;
         r_mem_r   <= 1'b0;
         r_mem_w   <= 1'b0;
      end else if (bus.flush) begin
         r_valid   <= 1'b0;
         r_alu_res <= '0;
         r_st_val  <= '0;
         r_dest    <= '0;
         r_wb_en   <= 1'b0;
         r_mem_r   <= 1'b0;
         r_mem_w   <= 1'b0;
      end else if (!bus.freeze) begin
         r_valid   <= bus.exe_valid;
         r_alu_res <= bus.alu_out;
         r_st_val  <= bus.st_val;
         r_dest    <= bus.dest;
         r_wb_en   <= bus.wb_en & bus.exe_valid;
         r_mem_r   <= bus.mem_r & bus.exe_valid;
         r_mem_w   <= bus.mem_w & bus.exe_valid;
      end
   end

   // ID sees the registered (pre-update) status, never this cycle's flags
   cond_check u_cond_check (
      .id_cond   (bus.id_cond),
      .status    (r_status),
      .cond_pass (bus.cond_pass)
   );

   assign bus.status      = r_status;
   assign bus.status_c    = r_status[FLAG_C];
   assign bus.mem_valid   = r_valid;
   assign bus.mem_alu_res = r_alu_res;
   assign bus.mem_st_val  = r_st_val;
   assign bus.mem_dest    = r_dest;
   assign bus.mem_wb_en   = r_wb_en;
   assign bus.mem_mem_r   = r_mem_r;
   assign bus.mem_mem_w   = r_mem_w;
endmodule
`default_nettype wire

// File: tb/tb_exe_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_exe_mem_stage                                       |
// | Description : Directed and random bench for exe_mem_stage against a  |
// |               behavioural model of flags, status and EXE/MEM reg.    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_exe_mem_stage;
   import arm_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   exe_mem_stage_if #(.DATA_W(32), .REG_AW(4)) bus ();

   exe_mem_stage #(.DATA_W(32), .REG_AW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference state
   logic [3:0]  m_status;
   logic        m_valid, m_wb, m_rd, m_wr;
   logic [31:0] m_res, m_st;
   logic [3:0]  m_dest;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Flags from arithmetic meaning: unsigned carry / not-borrow, signed overflow
   function automatic logic [3:0] ref_flags(input logic [3:0] cmd, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] res,
                                             input logic [3:0] old);
      logic n, z, c, v;
      longint s, u, k;
      n = res[31];
      z = (res == 32'd0);
      c = old[1];
      v = old[0];
      if (cmd == ALU_ADD || cmd == ALU_ADC) begin
         k = (cmd == ALU_ADC && old[1]) ? 64'sd1 : 64'sd0;
         u = longint'(a) + longint'(b) + k;
         s = longint'($signed(a)) + longint'($signed(b)) + k;
         c = (u > 64'sh0_FFFF_FFFF);
         v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end else if (cmd == ALU_SUB || cmd == ALU_SBC) begin
         k = (cmd == ALU_SBC && !old[1]) ? 64'sd1 : 64'sd0;
         c = (longint'(a) >= longint'(b) + k);
         s = longint'($signed(a)) - longint'($signed(b)) - k;
         v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end else if (!(cmd == ALU_MOV || cmd == ALU_MVN || cmd == ALU_AND ||
                     cmd == ALU_ORR || cmd == ALU_EOR)) begin
         return old;
      end
      return {n, z, c, v};
   endfunction

   function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] st);
      logic n, z, c, v;
      {n, z, c, v} = st;
      case (cc)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return c;
         4'd3:  return !c;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return c && !z;
         4'd9:  return !c || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Result an ALU would produce, so the EXE inputs are self-consistent
   function automatic logic [31:0] alu_result(input logic [3:0] cmd, input logic [31:0] a,
                                               input logic [31:0] b, input logic c);
      case (cmd)
         ALU_MOV: return b;
         ALU_MVN: return ~b;
         ALU_ADD: return a + b;
         ALU_ADC: return a + b + {31'd0, c};
         ALU_SUB: return a - b;
         ALU_SBC: return a - b - {31'd0, !c};
         ALU_AND: return a & b;
         ALU_ORR: return a | b;
         ALU_EOR: return a ^ b;
         default: return $urandom;
      endcase
   endfunction

   task automatic model_reset();
      m_status = 4'b0000; m_valid = 0; m_wb = 0; m_rd = 0; m_wr = 0;
      m_res = 0; m_st = 0; m_dest = 0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".status"},    {60'd0, bus.status},    {60'd0, m_status});
      check({tag, ".status_c"},  {63'd0, bus.status_c},  {63'd0, m_status[1]});
      check({tag, ".mem_valid"}, {63'd0, bus.mem_valid}, {63'd0, m_valid});
      check({tag, ".alu_res"},   {32'd0, bus.mem_alu_res}, {32'd0, m_res});
      check({tag, ".st_val"},    {32'd0, bus.mem_st_val},  {32'd0, m_st});
      check({tag, ".dest"},      {60'd0, bus.mem_dest},  {60'd0, m_dest});
      check({tag, ".wb_en"},     {63'd0, bus.mem_wb_en}, {63'd0, m_wb});
      check({tag, ".mem_r"},     {63'd0, bus.mem_mem_r}, {63'd0, m_rd});
      check({tag, ".mem_w"},     {63'd0, bus.mem_mem_w}, {63'd0, m_wr});
   endtask

   task automatic drive(input logic vld, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic s,
                        input logic frz, input logic fl);
      bus.exe_valid = vld; bus.alu_cmd = cmd; bus.val1 = a; bus.val2 = b;
      bus.alu_out = res; bus.s_bit = s; bus.freeze = frz; bus.flush = fl;
      bus.wb_en = $urandom_range(0, 1); bus.mem_r = $urandom_range(0, 1);
      bus.mem_w = $urandom_range(0, 1); bus.dest = 4'($urandom);
      bus.st_val = $urandom;
   endtask

   // One clock: check the ID condition on current status, update model, clock, compare
   task automatic tick(input string tag);
      #1;
      check({tag, ".cond_pass"}, {63'd0, bus.cond_pass},
            {63'd0, ref_cond(bus.id_cond, m_status)});
      if (bus.exe_valid && bus.s_bit && !bus.flush && !bus.freeze)
         m_status = ref_flags(bus.alu_cmd, bus.val1, bus.val2, bus.alu_out, m_status);
      if (bus.flush) begin
         m_valid = 0; m_wb = 0; m_rd = 0; m_wr = 0; m_res = 0; m_st = 0; m_dest = 0;
      end else if (!bus.freeze) begin
         m_valid = bus.exe_valid;
         m_res   = bus.alu_out;
         m_st    = bus.st_val;
         m_dest  = bus.dest;
         m_wb    = bus.wb_en & bus.exe_valid;
         m_rd    = bus.mem_r & bus.exe_valid;
         m_wr    = bus.mem_w & bus.exe_valid;
      end
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic cond_probe(input string tag, input logic [3:0] cc, input logic exp);
      bus.id_cond = cc;
      #1;
      check(tag, {63'd0, bus.cond_pass}, {63'd0, exp});
   endtask

   initial begin
      logic [3:0]  cmd;
      logic [31:0] a, b;
      rst_n = 1'b0;
      bus.id_cond = COND_AL;
      drive(0, 4'd0, 0, 0, 0, 0, 0, 0);
      model_reset();
      @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Idle cycles after reset
      for (int i = 0; i < 3; i++) begin
         drive(0, 4'd0, 0, 0, 0, 0, 0, 0);
         tick("idle");
      end
      check("idle.status_const", {60'd0, bus.status}, 64'd0);
      cond_probe("idle.al", COND_AL, 1'b1);
      cond_probe("idle.eq", COND_EQ, 1'b0);

      // ADD with unsigned wrap to zero
      drive(1, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0, 0);
      tick("add");
      check("add.status_const", {60'd0, bus.status}, {60'd0, 4'b0110});
      cond_probe("add.eq", COND_EQ, 1'b1);
      cond_probe("add.hi", COND_HI, 1'b0);

      // SUB with signed overflow, then ADC consuming C=1
      drive(1, ALU_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1, 0, 0);
      tick("sub");
      check("sub.status_const", {60'd0, bus.status}, {60'd0, 4'b0011});
      cond_probe("sub.ge", COND_GE, 1'b0);
      cond_probe("sub.lt", COND_LT, 1'b1);
      drive(1, ALU_ADC, 32'd0, 32'd0, 32'd1, 1, 0, 0);
      tick("adc");
      check("adc.status_const", {60'd0, bus.status}, {60'd0, 4'b0000});

      // MOV keeps the C flag
      drive(1, ALU_SUB, 32'd5, 32'd3, 32'd2, 1, 0, 0);
      tick("sub2");
      drive(1, ALU_MOV, 32'd0, 32'h8000_0000, 32'h8000_0000, 1, 0, 0);
      tick("mov");
      check("mov.status_const", {60'd0, bus.status}, {60'd0, 4'b1010});

      // Flush and freeze together: bubble, flags untouched
      drive(1, ALU_ADD, 32'd1, 32'd1, 32'd2, 1, 1, 1);
      tick("flushfrz");
      check("flushfrz.valid_const", {63'd0, bus.mem_valid}, 64'd0);
      drive(1, ALU_ADD, 32'd7, 32'd8, 32'd15, 1, 1, 0);
      tick("frz_bubble");
      // Freeze holding a real instruction
      drive(1, ALU_EOR, 32'hF0F0_0000, 32'h0F0F_0000, 32'hFFFF_0000, 1, 0, 0);
      tick("eor");
      drive(1, ALU_SUB, 32'd1, 32'd2, 32'hFFFF_FFFF, 1, 1, 0);
      tick("frz_hold");

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         cmd = 4'($urandom);
         a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 - $urandom_range(0, 1) : $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
         bus.id_cond = 4'($urandom);
         drive($urandom_range(0, 7) != 0, cmd, a, b, alu_result(cmd, a, b, m_status[1]),
               $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 7) == 0);
         tick("rand");
      end

      // Asynchronous reset between edges
      drive(1, ALU_SUB, 32'd3, 32'd3, 32'd0, 1, 0, 0);
      tick("pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      bus.id_cond = COND_NE;
      drive(1, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1, 0, 0);
      tick("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
